// File: rtl/decode.sv
// Instruction decode stage: register file, immediate generation, control
// decode, in-stage branch resolution, hazard detection and the ID/EX register.
module decode #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instrucao,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] pc_branch_value,
    output logic            mux_sel,
    output logic            load_pc,
    output logic            load_if_id_register,
    output logic            if_flush,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
    } idex_t;

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    idex_t           idex_q, idex_d;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic            is_r, is_i, is_load, is_store, is_branch, is_jal, is_valid;
    logic            uses_rs1, uses_rs2;
    logic [XLEN-1:0] rd1, rd2, br_a, br_b;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, target;
    logic            taken, load_use_stall, branch_stall, stall;

    assign opcode = instrucao[6:0];
    assign rd     = instrucao[11:7];
    assign funct3 = instrucao[14:12];
    assign rs1    = instrucao[19:15];
    assign rs2    = instrucao[24:20];

    assign imm_i = {{20{instrucao[31]}}, instrucao[31:20]};
    assign imm_s = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
    assign imm_b = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                    instrucao[30:25], instrucao[11:8], 1'b0};
    assign imm_j = {{11{instrucao[31]}}, instrucao[31], instrucao[19:12],
                    instrucao[20], instrucao[30:21], 1'b0};

    // Opcode classification; branches other than beq/bne are treated as unsupported.
    always_comb begin
        is_r      = (opcode == OP_R);
        is_i      = (opcode == OP_I);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
        is_jal    = (opcode == OP_JAL);
        is_valid  = is_r | is_i | is_load | is_store | is_branch | is_jal;
        uses_rs1  = is_r | is_i | is_load | is_store | is_branch;
        uses_rs2  = is_r | is_store | is_branch;
    end

    // Register-file read with write-through of the same-cycle write-back.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0)
            rd1 = (wb_reg_write && wb_rd == rs1) ? wb_data : regs_q[rs1];
        if (rs2 != 5'd0)
            rd2 = (wb_reg_write && wb_rd == rs2) ? wb_data : regs_q[rs2];
    end

    // Branch operands: take a ready ALU result from EX/MEM, else the register file.
    always_comb begin
        br_a = rd1;
        br_b = rd2;
        if (mem_reg_write && !mem_mem_read && mem_rd != 5'd0 && mem_rd == rs1)
            br_a = mem_alu_result;
        if (mem_reg_write && !mem_mem_read && mem_rd != 5'd0 && mem_rd == rs2)
            br_b = mem_alu_result;
    end

    // Redirect target and taken decision; target wraps modulo 2^32.
    always_comb begin
        target = (pc_in - 32'd4) + (is_jal ? imm_j : imm_b);
        taken  = is_jal ||
                 (is_branch && ((funct3[0] == 1'b0) ? (br_a == br_b) : (br_a != br_b)));
    end

    // Hazard detection: load-use for any consumer, plus branch-specific operand hazards.
    always_comb begin
        load_use_stall = idex_q.mem_read && idex_q.rd != 5'd0 &&
                         ((uses_rs1 && idex_q.rd == rs1) || (uses_rs2 && idex_q.rd == rs2));
        branch_stall   = is_branch &&
                         ((idex_q.reg_write && idex_q.rd != 5'd0 &&
                           (idex_q.rd == rs1 || idex_q.rd == rs2)) ||
                          (mem_mem_read && mem_rd != 5'd0 &&
                           (mem_rd == rs1 || mem_rd == rs2)));
        stall          = load_use_stall || branch_stall;
    end

    // Fetch control; a stall freezes fetch and suppresses any redirect.
    always_comb begin
        load_pc             = 1'b1;
        load_if_id_register = 1'b1;
        mux_sel             = 1'b0;
        if_flush            = 1'b0;
        pc_branch_value     = (is_branch || is_jal) ? target : '0;
        if (stall) begin
            load_pc             = 1'b0;
            load_if_id_register = 1'b0;
        end else if (taken) begin
            mux_sel  = 1'b1;
            if_flush = 1'b1;
        end
    end

    // Next ID/EX contents; stalls and unsupported opcodes become an all-zero bubble.
    always_comb begin
        idex_d = '0;
        if (!stall && is_valid) begin
            idex_d.pc         = pc_in - 32'd4;
            idex_d.rs1_data   = is_jal ? pc_in : rd1;
            idex_d.rs2_data   = rd2;
            idex_d.rs1        = uses_rs1 ? rs1 : 5'd0;
            idex_d.rs2        = uses_rs2 ? rs2 : 5'd0;
            idex_d.rd         = (is_r || is_i || is_load || is_jal) ? rd : 5'd0;
            idex_d.alu_src    = is_i | is_load | is_store | is_jal;
            idex_d.mem_read   = is_load;
            idex_d.mem_write  = is_store;
            idex_d.reg_write  = is_r | is_i | is_load | is_jal;
            idex_d.mem_to_reg = is_load;
            if (is_i || is_load) idex_d.imm = imm_i;
            else if (is_store)   idex_d.imm = imm_s;
            else if (is_branch)  idex_d.imm = imm_b;
            if (is_r)
                idex_d.alu_op = {instrucao[30], funct3};
            else if (is_i)
                idex_d.alu_op = (funct3 == 3'b101 && instrucao[30]) ? 4'b1101
                                                                   : {1'b0, funct3};
        end
    end

    // Register-file next state: write-back to any register but x0.
    always_comb begin
        regs_d = regs_q;
        if (wb_reg_write && wb_rd != 5'd0)
            regs_d[wb_rd] = wb_data;
    end

    // State update; reset wins over write-back and stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q <= '0;
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
        end else begin
            idex_q <= idex_d;
            regs_q <= regs_d;
        end
    end

    assign ex_pc         = idex_q.pc;
    assign ex_rs1_data   = idex_q.rs1_data;
    assign ex_rs2_data   = idex_q.rs2_data;
    assign ex_imm        = idex_q.imm;
    assign ex_rs1        = idex_q.rs1;
    assign ex_rs2        = idex_q.rs2;
    assign ex_rd         = idex_q.rd;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_to_reg = idex_q.mem_to_reg;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage.
module tb_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_in, instrucao;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_reg_write, mem_mem_read;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] pc_branch_value;
    logic        mux_sel, load_pc, load_if_id_register, if_flush;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

    int n_checks = 0;
    int n_errors = 0;

    decode #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .instrucao(instrucao),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
        .pc_branch_value(pc_branch_value), .mux_sel(mux_sel), .load_pc(load_pc),
        .load_if_id_register(load_if_id_register), .if_flush(if_flush),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle(input logic [31:0] pc, input logic [31:0] ins);
        pc_in     = pc;
        instrucao = ins;
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        settle(32'h0, 32'h0);
        wb_reg_write = 1'b1;
        wb_rd        = r;
        wb_data      = v;
        tick();
        wb_reg_write = 1'b0;
    endtask

    task automatic chk_fetch(input string tag, input logic ld, input logic ms, input logic fl);
        chk({tag, ".load_pc"},  32'(load_pc), 32'(ld));
        chk({tag, ".load_ifid"}, 32'(load_if_id_register), 32'(ld));
        chk({tag, ".mux_sel"},  32'(mux_sel), 32'(ms));
        chk({tag, ".if_flush"}, 32'(if_flush), 32'(fl));
    endtask

    initial begin
        reset = 1'b1; pc_in = '0; instrucao = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0; mem_alu_result = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state with a zero instruction in IF/ID
        settle(32'h0, 32'h0);
        chk_fetch("rst", 1'b1, 1'b0, 1'b0);
        chk("rst.pcbr", pc_branch_value, 32'h0);
        chk("rst.ex_pc", ex_pc, 32'h0);
        chk("rst.ex_regw", 32'(ex_reg_write), 32'h0);
        tick();
        chk("bubble0.ex_pc", ex_pc, 32'h0);
        chk("bubble0.ex_rd", 32'(ex_rd), 32'h0);

        // WB x5=0x10 while add x6,x5,x5 decodes
        settle(32'h20, 32'h00528333);
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h10;
        tick();
        wb_reg_write = 1'b0;
        chk("wt.rs1", ex_rs1_data, 32'h10);
        chk("wt.rs2", ex_rs2_data, 32'h10);
        chk("wt.aluop", 32'(ex_alu_op), 32'h0);
        chk("wt.rd", 32'(ex_rd), 32'd6);
        chk("wt.pc", ex_pc, 32'h1C);
        chk("wt.regw", 32'(ex_reg_write), 32'h1);

        // Load-use: lw x5 then add x7,x5,x1
        settle(32'h24, 32'h00002283);
        tick();
        chk("lw.memrd", 32'(ex_mem_read), 32'h1);
        chk("lw.rd", 32'(ex_rd), 32'd5);
        chk("lw.m2r", 32'(ex_mem_to_reg), 32'h1);
        settle(32'h28, 32'h001283B3);
        chk_fetch("lu.stall", 1'b0, 1'b0, 1'b0);
        tick();
        chk("lu.bub_memrd", 32'(ex_mem_read), 32'h0);
        chk("lu.bub_regw", 32'(ex_reg_write), 32'h0);
        chk("lu.bub_rd", 32'(ex_rd), 32'h0);
        #1;
        chk_fetch("lu.release", 1'b1, 1'b0, 1'b0);
        tick();
        chk("lu.add_rd", 32'(ex_rd), 32'd7);
        chk("lu.add_rs1", 32'(ex_rs1), 32'd5);
        chk("lu.add_rs2", 32'(ex_rs2), 32'd1);
        chk("lu.add_rs1d", ex_rs1_data, 32'h10);

        // Branches: x1=x2=7
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        settle(32'h104, 32'h00208863);
        chk_fetch("beq.eq", 1'b1, 1'b1, 1'b1);
        chk("beq.eq.pcbr", pc_branch_value, 32'h110);
        tick();
        chk("beq.ex_regw", 32'(ex_reg_write), 32'h0);
        chk("beq.ex_pc", ex_pc, 32'h100);
        chk("beq.ex_imm", ex_imm, 32'h10);

        wb_write(5'd2, 32'd9);
        settle(32'h104, 32'h00208863);
        chk_fetch("beq.ne", 1'b1, 1'b0, 1'b0);
        chk("beq.ne.pcbr", pc_branch_value, 32'h110);
        settle(32'h104, 32'h00209863);
        chk_fetch("bne.ne", 1'b1, 1'b1, 1'b1);

        // Forwarding of x2 from EX/MEM makes beq equal again
        mem_reg_write = 1'b1; mem_rd = 5'd2; mem_alu_result = 32'd7;
        settle(32'h104, 32'h00208863);
        chk_fetch("fwd.beq", 1'b1, 1'b1, 1'b1);
        // Load in MEM producing x2: branch must stall
        mem_reg_write = 1'b0; mem_mem_read = 1'b1;
        #1;
        chk_fetch("memld.stall", 1'b0, 1'b0, 1'b0);
        mem_mem_read = 1'b0; mem_rd = '0; mem_alu_result = '0;

        // addi x3,x0,-1 then beq x3,x3: stall wins, then redirect
        settle(32'h200, 32'hFFF00193);
        tick();
        chk("addi.imm", ex_imm, 32'hFFFFFFFF);
        chk("addi.aluop", 32'(ex_alu_op), 32'h0);
        chk("addi.alusrc", 32'(ex_alu_src), 32'h1);
        settle(32'h204, 32'h00318863);
        chk_fetch("brst.stall", 1'b0, 1'b0, 1'b0);
        tick();
        chk("brst.bubble", 32'(ex_reg_write), 32'h0);
        #1;
        chk_fetch("brst.after", 1'b1, 1'b1, 1'b1);
        chk("brst.pcbr", pc_branch_value, 32'h210);

        // srai x3,x4,2 and sw x2,8(x1)
        settle(32'h300, 32'h40225193);
        tick();
        chk("srai.aluop", 32'(ex_alu_op), 32'hD);
        settle(32'h304, 32'h0020A423);
        tick();
        chk("sw.imm", ex_imm, 32'h8);
        chk("sw.memw", 32'(ex_mem_write), 32'h1);
        chk("sw.regw", 32'(ex_reg_write), 32'h0);
        chk("sw.rs2d", ex_rs2_data, 32'd9);

        // Unsupported opcode decodes as a bubble
        settle(32'h308, 32'h0000007F);
        chk_fetch("unk", 1'b1, 1'b0, 1'b0);
        chk("unk.pcbr", pc_branch_value, 32'h0);
        tick();
        chk("unk.regw", 32'(ex_reg_write), 32'h0);

        // jal x1,-8 at address 0
        settle(32'h4, 32'hFF9FF0EF);
        chk_fetch("jal", 1'b1, 1'b1, 1'b1);
        chk("jal.pcbr", pc_branch_value, 32'hFFFFFFF8);
        tick();
        chk("jal.rs1d", ex_rs1_data, 32'h4);
        chk("jal.regw", 32'(ex_reg_write), 32'h1);
        chk("jal.imm", ex_imm, 32'h0);
        chk("jal.alusrc", 32'(ex_alu_src), 32'h1);
        chk("jal.rd", 32'(ex_rd), 32'd1);

        // x0 write is discarded, including same-cycle write-through
        settle(32'h400, 32'h00000333);
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        wb_reg_write = 1'b0;
        chk("x0.wt", ex_rs1_data, 32'h0);
        tick();
        chk("x0.read", ex_rs1_data, 32'h0);

        // Reset overrides a pending load-use stall and a write-back
        settle(32'h500, 32'h00002283);
        tick();
        settle(32'h504, 32'h001283B3);
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
        reset = 1'b1;
        tick();
        reset = 1'b0; wb_reg_write = 1'b0;
        chk("rst2.memrd", 32'(ex_mem_read), 32'h0);
        chk("rst2.pc", ex_pc, 32'h0);
        settle(32'h600, 32'h00208333);
        tick();
        chk("rst2.x1", ex_rs1_data, 32'h0);
        chk("rst2.x2", ex_rs2_data, 32'h0);
        settle(32'h604, 32'h00948333);
        tick();
        chk("rst2.x9", ex_rs1_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 clock  in  1  rising-edge clock for the register file and the ID/EX register.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc_in  in  32  IF/ID PC value, equal to the fetched instruction address + 4.
REQ-005 instrucao  in  32  IF/ID instruction word.
REQ-006 wb_reg_write, wb_rd, wb_data  in  1/5/32  write-back port to the register file.
REQ-007 mem_reg_write, mem_mem_read, mem_rd, mem_alu_result  in  1/1/5/32  EX/MEM state used for branch hazards and forwarding.
REQ-008 pc_branch_value  out  32  redirect target sent to fetch.
REQ-009 mux_sel, load_pc, load_if_id_register, if_flush  out  1 each  fetch control signals.
REQ-010 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32 each  ID/EX data fields.
REQ-011 ex_rs1, ex_rs2, ex_rd  out  5 each  ID/EX register indices.
REQ-012 ex_alu_op  out  4  ALU operation field.
REQ-013 ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  ID/EX control bits.

Function
REQ-014 Register file: 32 x 32-bit; x0 always reads 0.
REQ-015 Register-file write: wb_data is written on the clock edge when wb_reg_write=1 and wb_rd!=0.
REQ-016 Register-file read: asynchronous, with write-through; same-cycle wb_rd==rs returns wb_data.
REQ-017 Supported instructions: R-type 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011 (beq, bne only), jal 1101111.
REQ-018 Any other opcode, including 0x00000000, SHALL decode as a bubble: all control bits 0, no redirect.
REQ-019 Immediate generation: I, S, B and J formats, sign-extended to 32 bits.
REQ-020 Immediate encoding: B and J immediates have bit0=0.
REQ-021 ex_alu_op for R-type: {funct7[5], funct3}.
REQ-022 ex_alu_op for I-ALU: {0, funct3}, except srai, which SHALL be {1,101}.
REQ-023 ex_alu_op for load, store and jal: 0000.
REQ-024 jal: ex_rs1_data=pc_in, ex_imm=0, ex_alu_src=1, ex_reg_write=1, so that EX produces the link value.
REQ-025 Branch compare and target computation are done in this stage.
REQ-026 Branch/jal target: (pc_in-4)+imm, modulo 2^32.
REQ-027 Branch operand forwarding: operand from mem_alu_result when mem_reg_write=1, !mem_mem_read, mem_rd!=0 and mem_rd==rs; otherwise from the register-file read.
REQ-028 Load-use stall: ex_mem_read=1, ex_rd!=0, and ex_rd equals an rs1/rs2 actually used by the ID instruction.
REQ-029 Branch stall: branch opcode and either (ex_reg_write=1, ex_rd!=0, ex_rd==rs1 or rs2) or (mem_mem_read=1, mem_rd!=0, mem_rd==rs1 or rs2).
REQ-030 On stall: load_pc=0, load_if_id_register=0, mux_sel=0, if_flush=0; the ID/EX register loads a bubble on the next edge.
REQ-031 Redirect, no stall, branch taken (beq equal / bne unequal) or jal: mux_sel=1, pc_branch_value=target, if_flush=1, load_pc=1, load_if_id_register=1.
REQ-032 Redirect, no stall, branch not taken: mux_sel=0, if_flush=0.
REQ-033 Default outputs (no stall, no redirect): load_pc=1, load_if_id_register=1, mux_sel=0, if_flush=0.
REQ-034 pc_branch_value SHALL show the computed target whenever the instruction is a branch or jal, and 0 otherwise.
REQ-035 Stall SHALL take priority over redirect in the same cycle; the branch is re-evaluated after the stall.
REQ-036 Fetch control outputs are combinational; ID/EX outputs change only on a clock edge.
REQ-037 ID/EX contents: ex_pc=pc_in-4; branch and store instructions SHALL carry ex_reg_write=0.

Reset
REQ-038 reset=1 at an edge SHALL clear all ID/EX fields to 0.
REQ-039 reset=1 at an edge SHALL clear all 32 register-file entries to 0.
REQ-040 Reset SHALL override any pending stall or write-back in that cycle.
REQ-041 With the IF/ID register at reset (instrucao=0): load_pc=1, mux_sel=0, if_flush=0.

Verification
REQ-042 Reset, then instrucao=0 -> ID/EX all zero; load_pc=1; load_if_id_register=1; if_flush=0.
REQ-043 WB writes x5=0x10 while ID decodes add x6,x5,x5 in the same cycle -> ex_rs1_data=ex_rs2_data=0x10 and ex_alu_op=0000 after the edge.
REQ-044 lw x5 in EX, ID add x7,x5,x1 -> load_pc=0 and load_if_id_register=0 for 1 cycle, a bubble in ID/EX, then the add issues.
REQ-045 beq x1,x2,+16 with pc_in=0x104, x1=x2=7 -> mux_sel=1, if_flush=1, pc_branch_value=0x110.
REQ-046 Same beq with x1!=x2 -> mux_sel=0, if_flush=0.
REQ-047 jal x1,-8 at address 0x0 -> target 0xFFFFFFF8 (wrap-around); ex_rs1_data=0x4; ex_reg_write=1.
REQ-048 A write to x0 followed by reading x0 -> 0.
